// File: rtl/fmul_arbiter.sv
// Round-robin arbiter that shares one fixed-latency multiplier among NUM_REQ requesters.
// Results return in issue order through a credit-guarded FIFO. Optional packet lock: FMUL_ARB_PKT_LOCK_EN.
module fmul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BIT_SIZE   = 32,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*BIT_SIZE-1:0]  req_a,
    input  logic [NUM_REQ*BIT_SIZE-1:0]  req_b,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BIT_SIZE-1:0]          mul_a,
    output logic [BIT_SIZE-1:0]          mul_b,
    output logic                         mul_valid,
    input  logic [BIT_SIZE-1:0]          mul_res,
    output logic [BIT_SIZE-1:0]          out_data,
    output logic [ID_W-1:0]              out_id,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [LATENCY-1:0]  pv_q, pv_d;
    logic [LATENCY-1:0]  plast_q, plast_d;
    logic [ID_W-1:0]     pid_q [LATENCY];
    logic [ID_W-1:0]     pid_d [LATENCY];

    logic [BIT_SIZE-1:0] mem_data_q [FIFO_DEPTH];
    logic [ID_W-1:0]     mem_id_q   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;

    logic                found;
    logic [ID_W-1:0]     grant;
    logic                credit;
    logic                issue;
    logic                push;
    logic                pop;
    logic                locked;
    logic [ID_W-1:0]     lock_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FMUL_ARB_PKT_LOCK_EN
    typedef enum logic {OPEN, LOCKED} lock_state_e;

    lock_state_e     state_q, state_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    // A beat without last claims the multiplier until the same requester sends its last beat.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            OPEN: begin
                if (issue && !req_last[grant]) begin
                    state_d   = LOCKED;
                    lock_id_d = grant;
                end
            end
            LOCKED: begin
                if (issue && req_last[grant]) begin
                    state_d = OPEN;
                end
            end
            default: state_d = OPEN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= OPEN;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    assign locked  = (state_q == LOCKED);
    assign lock_id = lock_id_q;
`else
    assign locked  = 1'b0;
    assign lock_id = '0;
`endif

    // Search starts just after the last issuer so every requester gets a turn.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = ptr_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req_valid[idx] && (!locked || ID_W'(idx) == lock_id)) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    assign credit    = (cnt_q < CNT_W'(FIFO_DEPTH));
    assign issue     = found && credit && !rst;
    assign req_ready = issue ? (NUM_REQ'(1) << grant) : '0;
    assign mul_valid = issue;
    assign mul_a     = req_a[int'(grant)*BIT_SIZE +: BIT_SIZE];
    assign mul_b     = req_b[int'(grant)*BIT_SIZE +: BIT_SIZE];

    // Tag pipeline travels alongside the multiplier so the tag emerges with its result.
    always_comb begin
        pv_d       = '0;
        plast_d    = '0;
        pv_d[0]    = issue;
        plast_d[0] = req_last[grant];
        pid_d[0]   = grant;
        for (int k = 1; k < LATENCY; k++) begin
            pv_d[k]    = pv_q[k-1];
            plast_d[k] = plast_q[k-1];
            pid_d[k]   = pid_q[k-1];
        end
    end

    assign push      = pv_q[LATENCY-1];
    assign out_valid = (fcnt_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        cnt_d  = cnt_q;
        fcnt_d = fcnt_q;
        wr_d   = push ? ptr_inc(wr_q) : wr_q;
        rd_d   = pop  ? ptr_inc(rd_q) : rd_q;
        ptr_d  = issue ? grant : ptr_q;
        case ({issue, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            fcnt_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            pv_q    <= '0;
            plast_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pid_q[k] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            pv_q    <= pv_d;
            plast_q <= plast_d;
            for (int k = 0; k < LATENCY; k++) begin
                pid_q[k] <= pid_d[k];
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_q] <= mul_res;
            mem_id_q[wr_q]   <= pid_q[LATENCY-1];
            mem_last_q[wr_q] <= plast_q[LATENCY-1];
        end
    end

    assign out_data = mem_data_q[rd_q];
    assign out_id   = mem_id_q[rd_q];
    assign out_last = mem_last_q[rd_q];
    assign busy     = (cnt_q != '0);

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: float multiplier model plus an in-order result scoreboard.
module tb_fmul_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int BIT_SIZE   = 32;
    localparam int LATENCY    = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int ID_W       = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  id;
        logic        last;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic [NUM_REQ*BIT_SIZE-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]          req_valid, req_last, req_ready;
    logic [BIT_SIZE-1:0]         mul_a, mul_b, mul_res, out_data;
    logic                        mul_valid, out_last, out_valid, out_ready, busy;
    logic [ID_W-1:0]             out_id;

    exp_t        exp_q[$];
    logic [31:0] mpipe [LATENCY];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    fmul_arbiter #(
        .NUM_REQ(NUM_REQ), .BIT_SIZE(BIT_SIZE), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_res(mul_res),
        .out_data(out_data), .out_id(out_id), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    // Single-precision multiply for normal operands, routed through double and truncated back.
    function automatic logic [31:0] fmul32(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, dp;
        real rp;
        da = {a[31], 11'(int'(a[30:23]) - 127 + 1023), a[22:0], 29'd0};
        db = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        rp = $bitstoreal(da) * $bitstoreal(db);
        dp = $realtobits(rp);
        return {dp[63], 8'(int'(dp[62:52]) - 1023 + 127), dp[51:29]};
    endfunction

    // Multiplier model: result valid exactly LATENCY cycles after the issue cycle.
    always @(posedge clk) begin
        mpipe[0] <= fmul32(mul_a, mul_b);
        for (int k = 1; k < LATENCY; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_res = mpipe[LATENCY-1];

    // Scoreboard push from the bench's own operands whenever a handshake completes.
    always @(posedge clk) begin
        exp_t pe;
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    pe.data = fmul32(req_a[i*32 +: 32], req_b[i*32 +: 32]);
                    pe.id   = 2'(i);
                    pe.last = req_last[i];
                    exp_q.push_back(pe);
                end
            end
        end
    end

    task test_reset;
        rst = 1'b0; req_valid = '1; req_last = '1; out_ready = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_req_ready got=%b want=0000", req_ready); else n_pass++;
        n_checks++; if (mul_valid !== 1'b0) $display("[TB] FAIL reset_mul_valid got=%b want=0", mul_valid); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", busy); else n_pass++;
    endtask

    task test_round_robin;
        exp_t e;
        logic [3:0] want;
        @(negedge clk); rst = 1'b0; req_valid = '1; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            want = 4'(1 << (c % 4));
            n_checks++; if (req_ready !== want) $display("[TB] FAIL rr_grant cyc=%0d got=%b want=%b", c, req_ready, want); else n_pass++;
            n_checks++; if (out_valid !== (c >= LATENCY + 1)) $display("[TB] FAIL rr_first_out cyc=%0d got=%b want=%b", c, out_valid, c >= LATENCY + 1); else n_pass++;
            if (out_valid) begin
                n_checks++; if (out_id !== 2'((c - LATENCY - 1) % 4)) $display("[TB] FAIL rr_out_id cyc=%0d got=%0d want=%0d", c, out_id, (c - LATENCY - 1) % 4); else n_pass++;
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL rr_beat unexpected id=%0d", out_id);
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_id !== e.id || out_last !== e.last)
                        $display("[TB] FAIL rr_beat got=%h/%0d/%b want=%h/%0d/%b", out_data, out_id, out_last, e.data, e.id, e.last);
                    else n_pass++;
                end
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); req_valid = '0; #1;
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL rr_drain_beat unexpected id=%0d", out_id);
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_id !== e.id || out_last !== e.last)
                        $display("[TB] FAIL rr_drain_beat got=%h/%0d/%b want=%h/%0d/%b", out_data, out_id, out_last, e.data, e.id, e.last);
                    else n_pass++;
                end
            end else if (exp_q.size() == 0 && !busy) break;
        end
        n_checks++; if (exp_q.size() != 0 || busy !== 1'b0) $display("[TB] FAIL rr_drain left=%0d busy=%b want 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    task test_single_float;
        int beats;
        @(negedge clk);
        req_a[64 +: 32] = 32'h4000_0000; req_b[64 +: 32] = 32'h4040_0000;
        req_valid = 4'b0100; req_last = 4'b0100; out_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0100) $display("[TB] FAIL float_grant got=%b want=0100", req_ready); else n_pass++;
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); req_valid = '0; #1;
            if (out_valid) begin
                beats++;
                n_checks++; if (out_data !== 32'h40C0_0000) $display("[TB] FAIL float_data got=%h want=40c00000", out_data); else n_pass++;
                n_checks++; if (out_id !== 2'd2 || out_last !== 1'b1) $display("[TB] FAIL float_tag got=%0d/%b want=2/1", out_id, out_last); else n_pass++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
        n_checks++; if (beats != 1) $display("[TB] FAIL float_beats got=%0d want=1", beats); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL float_busy got=%b want=0", busy); else n_pass++;
    endtask

    task test_backpressure;
        exp_t e;
        int issues;
        issues = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); out_ready = 1'b0; req_valid = '1; req_last = '1; #1;
            issues += $countones(req_ready);
            n_checks++; if ($countones(req_ready) > 1) $display("[TB] FAIL bp_onehot got=%b want<=1 bit", req_ready); else n_pass++;
        end
        n_checks++; if (issues != FIFO_DEPTH) $display("[TB] FAIL bp_issues got=%0d want=%0d", issues, FIFO_DEPTH); else n_pass++;
        n_checks++; if (busy !== 1'b1 || out_valid !== 1'b1) $display("[TB] FAIL bp_full busy=%b out_valid=%b want 1/1", busy, out_valid); else n_pass++;
        @(negedge clk); out_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL bp_ready_indep got=%b want=0000", req_ready); else n_pass++;
        n_checks++;
        if (!out_valid || exp_q.size() == 0) $display("[TB] FAIL bp_pop out_valid=%b queued=%0d want 1/>0", out_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_id !== e.id) $display("[TB] FAIL bp_pop got=%h/%0d want=%h/%0d", out_data, out_id, e.data, e.id);
            else n_pass++;
        end
        issues = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); out_ready = 1'b0; #1;
            issues += $countones(req_ready);
        end
        n_checks++; if (issues != 1) $display("[TB] FAIL bp_refill got=%0d want=1", issues); else n_pass++;
    endtask

    task test_simultaneous;
        exp_t e;
        int issues, beats;
        issues = 0; beats = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); out_ready = 1'b1; #1;
            if (c == 0) begin
                n_checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL sim_full_ready got=%b want=0000", req_ready); else n_pass++;
            end
            issues += $countones(req_ready);
            if (out_valid) begin
                beats++;
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL sim_beat unexpected id=%0d", out_id);
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_id !== e.id || out_last !== e.last)
                        $display("[TB] FAIL sim_beat got=%h/%0d/%b want=%h/%0d/%b", out_data, out_id, out_last, e.data, e.id, e.last);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (issues != 9) $display("[TB] FAIL sim_issues got=%0d want=9", issues); else n_pass++;
        n_checks++; if (beats != 10) $display("[TB] FAIL sim_beats got=%0d want=10", beats); else n_pass++;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); req_valid = '0; #1;
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL sim_drain_beat unexpected id=%0d", out_id);
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_id !== e.id || out_last !== e.last)
                        $display("[TB] FAIL sim_drain_beat got=%h/%0d/%b want=%h/%0d/%b", out_data, out_id, out_last, e.data, e.id, e.last);
                    else n_pass++;
                end
            end else if (exp_q.size() == 0 && !busy) break;
        end
        n_checks++; if (exp_q.size() != 0 || busy !== 1'b0) $display("[TB] FAIL sim_drain left=%0d busy=%b want 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    task test_reset_midflight;
        int issues, beats;
        issues = 0; beats = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); req_valid = '1; out_ready = 1'b1; #1;
            issues += $countones(req_ready);
        end
        n_checks++; if (issues != 3) $display("[TB] FAIL mid_issues got=%0d want=3", issues); else n_pass++;
        @(negedge clk); rst = 1'b1; req_valid = '0; #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL mid_reset out_valid=%b busy=%b want 0/0", out_valid, busy); else n_pass++;
        n_checks++; if (mul_valid !== 1'b0 || req_ready !== 4'b0000) $display("[TB] FAIL mid_reset_issue mul_valid=%b ready=%b want 0/0000", mul_valid, req_ready); else n_pass++;
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (out_valid) beats++;
        end
        n_checks++; if (beats != 0) $display("[TB] FAIL mid_stale got=%0d beats want=0", beats); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL mid_busy got=%b want=0", busy); else n_pass++;
    endtask

    task test_pkt_lock;
        exp_t e;
        int exp_ids [6];
        int beat1;
`ifdef FMUL_ARB_PKT_LOCK_EN
        exp_ids = '{1, 1, 1, 0, 0, 0};
`else
        exp_ids = '{1, 0, 1, 0, 1, 0};
`endif
        @(negedge clk); req_valid = 4'b0001; req_last = 4'b0001; out_ready = 1'b1; #1;
        n_checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL lock_pre got=%b want=0001", req_ready); else n_pass++;
        beat1 = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = 4'b0001; req_valid[1] = (beat1 < 3);
            req_last  = 4'b0001; req_last[1]  = (beat1 == 2);
            #1;
            n_checks++; if (req_ready !== 4'(1 << exp_ids[c])) $display("[TB] FAIL lock_grant cyc=%0d got=%b want=%b", c, req_ready, 4'(1 << exp_ids[c])); else n_pass++;
            if (req_ready[1]) beat1++;
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL lock_beat unexpected id=%0d", out_id);
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_id !== e.id || out_last !== e.last)
                        $display("[TB] FAIL lock_beat got=%h/%0d/%b want=%h/%0d/%b", out_data, out_id, out_last, e.data, e.id, e.last);
                    else n_pass++;
                end
            end
        end
        n_checks++; if (beat1 != 3) $display("[TB] FAIL lock_beats1 got=%0d want=3", beat1); else n_pass++;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); req_valid = '0; #1;
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL lock_drain_beat unexpected id=%0d", out_id);
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_id !== e.id || out_last !== e.last)
                        $display("[TB] FAIL lock_drain_beat got=%h/%0d/%b want=%h/%0d/%b", out_data, out_id, out_last, e.data, e.id, e.last);
                    else n_pass++;
                end
            end else if (exp_q.size() == 0 && !busy) break;
        end
        n_checks++; if (exp_q.size() != 0 || busy !== 1'b0) $display("[TB] FAIL lock_drain left=%0d busy=%b want 0/0", exp_q.size(), busy); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        req_valid = '0; req_last = '0; out_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*32 +: 32] = {1'b0, 8'd128, 23'(i * 32'h1357 + 1)};
            req_b[i*32 +: 32] = {1'b0, 8'(127 + i % 2), 23'(i * 32'h0A1 + 3)};
        end
        test_reset();
        test_round_robin();
        test_single_float();
        test_backpressure();
        test_simultaneous();
        test_reset_midflight();
        test_pkt_lock();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
